alu_cmd_driver: RTL

//  Command-side master for the combinational ALU: accepts operation commands over a

---
 rtl/alu_cmd_driver_if.sv | 52 +++++
 rtl/alu_cmd_driver.sv | 109 ++++++++++
 2 files changed

// File: rtl/alu_cmd_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_driver_if
// Purpose  : Command, ALU-drive and response signals of alu_cmd_driver.
//            With ALU_FLAGS_EN defined the response carries zero/neg flags.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_cmd_driver_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic [1:0]       cmd_op_i;
    logic [WIDTH-1:0] cmd_a_i;
    logic [WIDTH-1:0] cmd_b_i;
    logic             cmd_use_acc_i;
    logic [WIDTH-1:0] alu_a_o;
    logic [WIDTH-1:0] alu_b_o;
    logic [1:0]       alu_opcode_o;
    logic [WIDTH-1:0] alu_result_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [WIDTH-1:0] rsp_data_o;
    logic [1:0]       rsp_op_o;
`ifdef ALU_FLAGS_EN
    logic             rsp_zero_o;
    logic             rsp_neg_o;
`endif

    // Driver side
    modport master (
`ifdef ALU_FLAGS_EN
        output rsp_zero_o, rsp_neg_o,
`endif
        input  cmd_valid_i, cmd_op_i, cmd_a_i, cmd_b_i, cmd_use_acc_i,
        input  alu_result_i, rsp_ready_i,
        output cmd_ready_o, alu_a_o, alu_b_o, alu_opcode_o,
        output rsp_valid_o, rsp_data_o, rsp_op_o
    );

    // Sequencer + ALU side
    modport slave (
`ifdef ALU_FLAGS_EN
        input  rsp_zero_o, rsp_neg_o,
`endif
        output cmd_valid_i, cmd_op_i, cmd_a_i, cmd_b_i, cmd_use_acc_i,
        output alu_result_i, rsp_ready_i,
        input  cmd_ready_o, alu_a_o, alu_b_o, alu_opcode_o,
        input  rsp_valid_o, rsp_data_o, rsp_op_o
    );
endinterface
`default_nettype wire

// File: rtl/alu_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_driver
// Purpose  : Registers ALU operands from a valid/ready command, captures the
//            ALU result into an accumulator and returns it on a response channel.
//            Optional feature macro: ALU_FLAGS_EN (zero/neg response flags).
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_driver #(
    parameter int WIDTH = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    alu_cmd_driver_if.master   bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [1:0]       alu_op_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic [1:0]       rsp_op_q;
    logic             cmd_ready;
    logic             rsp_valid;
    logic             cmd_fire;
    logic             rsp_fire;

    assign cmd_fire = bus.cmd_valid_i && cmd_ready;
    assign rsp_fire = rsp_valid && bus.rsp_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_fire) state_d = S_EXEC;
            S_EXEC:  state_d = S_RESP;
            S_RESP:  if (rsp_fire) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_RESP);
    end

    // Operands are only loaded at acceptance, so they stay frozen through EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= 2'd0;
            rsp_data_q <= '0;
            rsp_op_q   <= 2'd0;
        end else begin
            if (cmd_fire) begin
                alu_a_q  <= bus.cmd_use_acc_i ? acc_q : bus.cmd_a_i;
                alu_b_q  <= bus.cmd_b_i;
                alu_op_q <= bus.cmd_op_i;
            end
            if (state_q == S_EXEC) begin
                rsp_data_q <= bus.alu_result_i;
                acc_q      <= bus.alu_result_i;
                rsp_op_q   <= alu_op_q;
            end
        end
    end

`ifdef ALU_FLAGS_EN
    logic rsp_zero_q;
    logic rsp_neg_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_zero_q <= 1'b0;
            rsp_neg_q  <= 1'b0;
        end else if (state_q == S_EXEC) begin
            rsp_zero_q <= (bus.alu_result_i == '0);
            rsp_neg_q  <= bus.alu_result_i[WIDTH-1];
        end
    end

    assign bus.rsp_zero_o = rsp_zero_q;
    assign bus.rsp_neg_o  = rsp_neg_q;
`else
    // Plain response channel: no flag state.
`endif

    assign bus.cmd_ready_o  = cmd_ready;
    assign bus.rsp_valid_o  = rsp_valid;
    assign bus.alu_a_o      = alu_a_q;
    assign bus.alu_b_o      = alu_b_q;
    assign bus.alu_opcode_o = alu_op_q;
    assign bus.rsp_data_o   = rsp_data_q;
    assign bus.rsp_op_o     = rsp_op_q;
endmodule
`default_nettype wire
